mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter in front of a single-port RAM
// with a fixed one-cycle read latency.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   pN_rq_en / pN_rq_rdy          request offer / acceptance (N = 0, 1)
//   pN_rq_addr, pN_rq_iswrite,
//   pN_rq_data                    request byte address, direction, write data
//   pN_rs_en / pN_rs_rdy          response valid / requester can take it
//   pN_rs_data                    response data (0 whenever pN_rs_en = 0)
//   mem_rq_en, mem_addr,
//   mem_write_enable, mem_write   RAM request, driven combinationally
//   mem_rs_en, mem_read           RAM response, one cycle after mem_rq_en
//
// Handshake: a request transfers in a cycle where pN_rq_en && pN_rq_rdy; a
// response transfers in a cycle where pN_rs_en && pN_rs_rdy. pN_rs_en stays
// high, with stable data, until the response transfers.
//
// Every accepted request (read, write, or out-of-range) yields exactly one
// response. A response is delivered straight from the RAM when the requester
// is ready, otherwise it parks in a one-entry per-port buffer. A port is not
// granted while its buffer is full, or while its in-flight response is about
// to land in that buffer, so the buffer can never overflow.
module mem_arbiter #(
  parameter int LGSZW = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               p0_rq_en,
  output logic               p0_rq_rdy,
  input  logic [31:0]        p0_rq_addr,
  input  logic               p0_rq_iswrite,
  input  logic [31:0]        p0_rq_data,
  output logic               p0_rs_en,
  input  logic               p0_rs_rdy,
  output logic [31:0]        p0_rs_data,
  input  logic               p1_rq_en,
  output logic               p1_rq_rdy,
  input  logic [31:0]        p1_rq_addr,
  input  logic               p1_rq_iswrite,
  input  logic [31:0]        p1_rq_data,
  output logic               p1_rs_en,
  input  logic               p1_rs_rdy,
  output logic [31:0]        p1_rs_data,
  output logic               mem_rq_en,
  output logic [LGSZW+1:0]   mem_addr,
  output logic               mem_write_enable,
  output logic [31:0]        mem_write,
  input  logic               mem_rs_en,
  input  logic [31:0]        mem_read
);

  // Registered state
  logic        inflight_valid_q, inflight_valid_d;
  logic        inflight_port_q,  inflight_port_d;
  logic        inflight_oor_q,   inflight_oor_d;
  logic        last_q,           last_d;
  logic [1:0]  buf_valid_q,      buf_valid_d;
  logic [31:0] buf_data_q [2];
  logic [31:0] buf_data_d [2];

  // Per-port views of the request/response ports
  logic [1:0]  rq_en, rq_iswrite, rs_rdy, elig, gnt, rs_en;
  logic [31:0] rq_addr [2];
  logic [31:0] rq_data [2];
  logic [31:0] rs_data [2];

  logic        sel;
  logic [31:0] sel_addr;
  logic        sel_oor;
  logic [31:0] resp_data;

  always_comb begin
    rq_en      = {p1_rq_en, p0_rq_en};
    rq_iswrite = {p1_rq_iswrite, p0_rq_iswrite};
    rs_rdy     = {p1_rs_rdy, p0_rs_rdy};
    rq_addr[0] = p0_rq_addr;
    rq_addr[1] = p1_rq_addr;
    rq_data[0] = p0_rq_data;
    rq_data[1] = p1_rq_data;
  end

  // Eligibility and round-robin grant
  always_comb begin
    elig = 2'b00;
    for (int i = 0; i < 2; i++) begin
      // An in-flight response headed for a stalled requester will occupy the
      // buffer next cycle, so that port must not issue another request now.
      elig[i] = rq_en[i] && !buf_valid_q[i] && !rst &&
                !(inflight_valid_q && (inflight_port_q == 1'(i)) && !rs_rdy[i]);
    end
    if (elig == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
    else               gnt = elig;
  end

  always_comb begin
    sel      = gnt[1];
    sel_addr = rq_addr[sel];
    sel_oor  = |(sel_addr >> (LGSZW + 2));

    mem_rq_en        = (|gnt) && !sel_oor;
    mem_addr         = mem_rq_en ? sel_addr[LGSZW+1:0] : '0;
    mem_write_enable = mem_rq_en && rq_iswrite[sel];
    mem_write        = mem_write_enable ? rq_data[sel] : 32'h0;

    p0_rq_rdy = gnt[0];
    p1_rq_rdy = gnt[1];

    inflight_valid_d = |gnt;
    inflight_port_d  = sel;
    inflight_oor_d   = sel_oor;
    last_d           = (|gnt) ? sel : last_q;
  end

  // Response steering: buffered data first, then the in-flight response.
  always_comb begin
    // Out-of-range requests never reach the RAM, so they answer with zero.
    resp_data = (inflight_oor_q || !mem_rs_en) ? 32'h0 : mem_read;
    for (int i = 0; i < 2; i++) begin
      rs_en[i]       = 1'b0;
      rs_data[i]     = 32'h0;
      buf_valid_d[i] = buf_valid_q[i];
      buf_data_d[i]  = buf_data_q[i];
      if (buf_valid_q[i]) begin
        rs_en[i]   = 1'b1;
        rs_data[i] = buf_data_q[i];
        if (rs_rdy[i]) buf_valid_d[i] = 1'b0;
      end else if (inflight_valid_q && (inflight_port_q == 1'(i))) begin
        rs_en[i]   = 1'b1;
        rs_data[i] = resp_data;
        if (!rs_rdy[i]) begin
          buf_valid_d[i] = 1'b1;
          buf_data_d[i]  = resp_data;
        end
      end
    end
    p0_rs_en   = rs_en[0];
    p1_rs_en   = rs_en[1];
    p0_rs_data = rs_data[0];
    p1_rs_data = rs_data[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_valid_q <= 1'b0;
      inflight_port_q  <= 1'b0;
      inflight_oor_q   <= 1'b0;
      last_q           <= 1'b1;  // port 0 wins the first contention
      buf_valid_q      <= 2'b00;
      buf_data_q[0]    <= 32'h0;
      buf_data_q[1]    <= 32'h0;
    end else begin
      inflight_valid_q <= inflight_valid_d;
      inflight_port_q  <= inflight_port_d;
      inflight_oor_q   <= inflight_oor_d;
      last_q           <= last_d;
      buf_valid_q      <= buf_valid_d;
      buf_data_q[0]    <= buf_data_d[0];
      buf_data_q[1]    <= buf_data_d[1];
    end
  end

endmodule
